// File: rtl/mbist_mem_responder.sv
// Single-port memory responder for an MBIST controller. Writes and reads
// complete in one cycle. One programmable fault can be injected: stuck-at-0,
// stuck-at-1, transition (no 0->1) or inversion coupling. Saturating counters
// track accepted writes and reads.
//
// Handshake: there is no back-pressure. An access is accepted on any posedge
// where we or re is high. A read (re=1, we=0) sampled at posedge N drives
// dataout and pulses rvalid during cycle N+1. we=re=1 performs the write,
// drops the read and pulses collision instead; dataout holds its old value.
module mbist_mem_responder #(
  parameter int CAWIDTH  = 4,
  parameter int DWIDTH   = 8,
  parameter int CNTWIDTH = 16,
  parameter int BITW     = $clog2(DWIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CAWIDTH-1:0]  CA,
  input  logic                we,
  input  logic                re,
  input  logic [DWIDTH-1:0]   datain,
  output logic [DWIDTH-1:0]   dataout,
  output logic                rvalid,
  output logic                collision,
  input  logic                fault_load,
  input  logic                fault_en,
  input  logic [1:0]          fault_type,
  input  logic [CAWIDTH-1:0]  fault_addr,
  input  logic [BITW-1:0]     fault_bit,
  input  logic [CAWIDTH-1:0]  fault_agg,
  output logic [CNTWIDTH-1:0] wr_count,
  output logic [CNTWIDTH-1:0] rd_count
);

  localparam int DEPTH = 1 << CAWIDTH;

  typedef enum logic [1:0] {
    FT_SA0  = 2'b00,
    FT_SA1  = 2'b01,
    FT_TFUP = 2'b10,
    FT_CFIN = 2'b11
  } fault_t;

  logic [DWIDTH-1:0]   r_mem [DEPTH];
  logic [DWIDTH-1:0]   r_dout;
  logic                r_rvalid;
  logic                r_collision;
  logic [CNTWIDTH-1:0] r_wr_count;
  logic [CNTWIDTH-1:0] r_rd_count;

  logic                r_f_en;
  fault_t              r_f_type;
  logic [CAWIDTH-1:0]  r_f_addr;
  logic [BITW-1:0]     r_f_bit;
  logic [CAWIDTH-1:0]  r_f_agg;

  logic [DWIDTH-1:0]   w_cur;
  logic [DWIDTH-1:0]   w_vmask;
  logic                w_hit_victim;
  logic [DWIDTH-1:0]   w_wdata;
  logic [DWIDTH-1:0]   w_rdata;
  logic                w_cf_fire;
  logic [DWIDTH-1:0]   w_victim_base;
  logic                w_rd_accept;

  // Fault-shaped write data, masked read data and coupling trigger for this access
  always_comb begin
    w_cur         = r_mem[CA];
    w_vmask       = DWIDTH'(1) << r_f_bit;
    w_hit_victim  = r_f_en && (CA == r_f_addr);
    w_wdata       = datain;
    w_rdata       = w_cur;
    if (w_hit_victim) begin
      case (r_f_type)
        FT_SA0: begin
          w_wdata = datain & ~w_vmask;
          w_rdata = w_cur & ~w_vmask;
        end
        FT_SA1: begin
          w_wdata = datain | w_vmask;
          w_rdata = w_cur | w_vmask;
        end
        FT_TFUP: begin
          // Victim stuck low only when a rising transition is attempted
          if (((w_cur & w_vmask) == '0) && ((datain & w_vmask) != '0)) begin
            w_wdata = datain & ~w_vmask;
          end
        end
        default: begin
        end
      endcase
    end
    // Coupling fires only when the aggressor word actually changes
    w_cf_fire     = r_f_en && (r_f_type == FT_CFIN) && we &&
                    (CA == r_f_agg) && (w_cur != datain);
    // When aggressor and victim share a word, invert on top of the new data
    w_victim_base = (r_f_addr == CA) ? w_wdata : r_mem[r_f_addr];
    w_rd_accept   = re && !we;
  end

  // Memory array: write lands first, coupling inversion overrides the victim word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (we) begin
      r_mem[CA] <= w_wdata;
      if (w_cf_fire) begin
        r_mem[r_f_addr] <= w_victim_base ^ w_vmask;
      end
    end
  end

  // Read data register and single-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout      <= '0;
      r_rvalid    <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_rvalid    <= w_rd_accept;
      r_collision <= we && re;
      if (w_rd_accept) begin
        r_dout <= w_rdata;
      end
    end
  end

  // Saturating access counters; collisions count as writes only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (we && (r_wr_count != {CNTWIDTH{1'b1}})) begin
        r_wr_count <= r_wr_count + CNTWIDTH'(1);
      end
      if (w_rd_accept && (r_rd_count != {CNTWIDTH{1'b1}})) begin
        r_rd_count <= r_rd_count + CNTWIDTH'(1);
      end
    end
  end

  // Fault configuration latch; the access in the loading cycle uses the old setting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_en   <= 1'b0;
      r_f_type <= FT_SA0;
      r_f_addr <= '0;
      r_f_bit  <= '0;
      r_f_agg  <= '0;
    end else if (fault_load) begin
      r_f_en   <= fault_en;
      r_f_type <= fault_t'(fault_type);
      r_f_addr <= fault_addr;
      r_f_bit  <= fault_bit;
      r_f_agg  <= fault_agg;
    end
  end

  assign dataout   = r_dout;
  assign rvalid    = r_rvalid;
  assign collision = r_collision;
  assign wr_count  = r_wr_count;
  assign rd_count  = r_rd_count;

endmodule

// File: tb/tb_mbist_mem_responder.sv
// Bench for mbist_mem_responder: directed March Y and fault scenarios with
// literal expectations, then randomized traffic against a word-level model.
module tb_mbist_mem_responder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  CA;
  logic        we;
  logic        re;
  logic [7:0]  datain;
  logic [7:0]  dataout;
  logic        rvalid;
  logic        collision;
  logic        fault_load;
  logic        fault_en;
  logic [1:0]  fault_type;
  logic [3:0]  fault_addr;
  logic [2:0]  fault_bit;
  logic [3:0]  fault_agg;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  mbist_mem_responder #(.CAWIDTH(4), .DWIDTH(8), .CNTWIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .CA(CA), .we(we), .re(re), .datain(datain),
    .dataout(dataout), .rvalid(rvalid), .collision(collision),
    .fault_load(fault_load), .fault_en(fault_en), .fault_type(fault_type),
    .fault_addr(fault_addr), .fault_bit(fault_bit), .fault_agg(fault_agg),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [16];
  logic [7:0]  m_dout;
  logic        m_rvalid;
  logic        m_coll;
  int          m_wr;
  int          m_rd;
  logic        m_fen;
  logic [1:0]  m_ftype;
  logic [3:0]  m_faddr;
  logic [2:0]  m_fbit;
  logic [3:0]  m_fagg;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] old_w;
    logic [7:0] new_w;
    logic [7:0] rd_w;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_dout = 8'h00; m_rvalid = 1'b0; m_coll = 1'b0;
      m_wr = 0; m_rd = 0;
      m_fen = 1'b0; m_ftype = 2'd0; m_faddr = 4'd0; m_fbit = 3'd0; m_fagg = 4'd0;
    end else begin
      m_rvalid = 1'b0;
      m_coll   = 1'b0;
      if (we) begin
        old_w = m_mem[CA];
        new_w = datain;
        if (m_fen && CA == m_faddr) begin
          if (m_ftype == 2'd0) new_w[m_fbit] = 1'b0;
          if (m_ftype == 2'd1) new_w[m_fbit] = 1'b1;
          if (m_ftype == 2'd2 && old_w[m_fbit] == 1'b0 && datain[m_fbit] == 1'b1)
            new_w[m_fbit] = 1'b0;
        end
        m_mem[CA] = new_w;
        if (m_fen && m_ftype == 2'd3 && CA == m_fagg && old_w != datain)
          m_mem[m_faddr][m_fbit] = ~m_mem[m_faddr][m_fbit];
        if (m_wr < 65535) m_wr++;
        m_coll = re;
      end else if (re) begin
        rd_w = m_mem[CA];
        if (m_fen && CA == m_faddr && m_ftype == 2'd0) rd_w[m_fbit] = 1'b0;
        if (m_fen && CA == m_faddr && m_ftype == 2'd1) rd_w[m_fbit] = 1'b1;
        m_dout   = rd_w;
        m_rvalid = 1'b1;
        if (m_rd < 65535) m_rd++;
      end
      if (fault_load) begin
        m_fen = fault_en; m_ftype = fault_type; m_faddr = fault_addr;
        m_fbit = fault_bit; m_fagg = fault_agg;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, outputs must match the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("dataout",   32'(dataout),   32'(m_dout));
      chk("rvalid",    32'(rvalid),    32'(m_rvalid));
      chk("collision", 32'(collision), 32'(m_coll));
      chk("wr_count",  32'(wr_count),  32'(m_wr));
      chk("rd_count",  32'(rd_count),  32'(m_rd));
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one access for one cycle starting at a negedge; returns at the next negedge.
  task automatic do_op(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    we = w; re = r; CA = a; datain = d;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  task automatic load_fault(input logic en, input logic [1:0] t, input logic [3:0] a,
                            input logic [2:0] b, input logic [3:0] g);
    fault_en = en; fault_type = t; fault_addr = a; fault_bit = b; fault_agg = g;
    fault_load = 1'b1;
    do_op(1'b0, 1'b0, 4'd0, 8'd0);
    fault_load = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [3:0] a, input logic [7:0] exp);
    do_op(1'b0, 1'b1, a, 8'd0);
    chk(name, 32'(dataout), 32'(exp));
    chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    we = 1'b0; re = 1'b0; fault_load = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dataout",   32'(dataout),   32'd0);
    chk("rst_rvalid",    32'(rvalid),    32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_wr_count",  32'(wr_count),  32'd0);
    chk("rst_rd_count",  32'(rd_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] a;
    logic [7:0] d;
    int sel;
    rst_n = 1'b1; CA = 4'd0; we = 1'b0; re = 1'b0; datain = 8'd0;
    fault_load = 1'b0; fault_en = 1'b0; fault_type = 2'd0;
    fault_addr = 4'd0; fault_bit = 3'd0; fault_agg = 4'd0;

    do_reset();

    // Clean March Y
    for (int i = 0; i < 16; i++) do_op(1'b1, 1'b0, 4'(i), 8'h00);
    for (int i = 0; i < 16; i++) begin
      read_expect("marchy_r0_up", 4'(i), 8'h00);
      do_op(1'b1, 1'b0, 4'(i), 8'hFF);
      read_expect("marchy_r1_up", 4'(i), 8'hFF);
    end
    for (int i = 15; i >= 0; i--) begin
      read_expect("marchy_r1_dn", 4'(i), 8'hFF);
      do_op(1'b1, 1'b0, 4'(i), 8'h00);
      read_expect("marchy_r0_dn", 4'(i), 8'h00);
    end
    for (int i = 0; i < 16; i++) read_expect("marchy_r0_final", 4'(i), 8'h00);
    // Three writes and five reads per address
    chk("marchy_wr_count", 32'(wr_count), 32'd48);
    chk("marchy_rd_count", 32'(rd_count), 32'd80);

    // SA1 at addr 5, bit 3
    do_reset();
    load_fault(1'b1, 2'b01, 4'd5, 3'd3, 4'd0);
    do_op(1'b1, 1'b0, 4'd5, 8'h00);
    read_expect("sa1_w00", 4'd5, 8'h08);
    do_op(1'b1, 1'b0, 4'd5, 8'hFF);
    read_expect("sa1_wff", 4'd5, 8'hFF);
    read_expect("sa1_neighbour", 4'd6, 8'h00);

    // TF-up at addr 2, bit 0
    load_fault(1'b1, 2'b10, 4'd2, 3'd0, 4'd0);
    do_op(1'b1, 1'b0, 4'd2, 8'h00);
    do_op(1'b1, 1'b0, 4'd2, 8'hFF);
    read_expect("tfup_rise_blocked", 4'd2, 8'hFE);
    load_fault(1'b0, 2'b10, 4'd2, 3'd0, 4'd0);
    do_op(1'b1, 1'b0, 4'd2, 8'hFF);
    read_expect("tfup_disabled", 4'd2, 8'hFF);

    // CFin aggressor 9, victim addr 4 bit 7
    do_reset();
    load_fault(1'b1, 2'b11, 4'd4, 3'd7, 4'd9);
    do_op(1'b1, 1'b0, 4'd4, 8'h00);
    do_op(1'b1, 1'b0, 4'd9, 8'h55);
    read_expect("cfin_invert", 4'd4, 8'h80);
    do_op(1'b1, 1'b0, 4'd9, 8'h55);
    read_expect("cfin_no_transition", 4'd4, 8'h80);

    // Collision drops the read, keeps dataout
    load_fault(1'b0, 2'b00, 4'd0, 3'd0, 4'd0);
    do_op(1'b1, 1'b0, 4'd1, 8'h11);
    read_expect("coll_setup", 4'd1, 8'h11);
    do_op(1'b1, 1'b1, 4'd3, 8'hA5);
    chk("coll_pulse",   32'(collision), 32'd1);
    chk("coll_rvalid",  32'(rvalid),    32'd0);
    chk("coll_dataout", 32'(dataout),   32'h11);
    read_expect("coll_write_landed", 4'd3, 8'hA5);

    // Reset mid-run clears array, counters and fault
    load_fault(1'b1, 2'b01, 4'd0, 3'd0, 4'd0);
    for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, 4'(i), 8'h3C);
    do_reset();
    read_expect("post_reset_a0", 4'd0, 8'h00);
    read_expect("post_reset_a2", 4'd2, 8'h00);

    // Randomized traffic with occasional fault reconfiguration
    for (int n = 0; n < 1500; n++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        load_fault(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)));
      end else begin
        case ($urandom_range(0, 2))
          0: a = 4'($urandom_range(0, 15));
          1: a = m_faddr;
          default: a = m_fagg;
        endcase
        d = ($urandom_range(0, 3) == 0) ? m_mem[a] : 8'($urandom);
        if (sel <= 9)       do_op(1'b1, 1'b0, a, d);
        else if (sel <= 17) do_op(1'b0, 1'b1, a, d);
        else if (sel == 18) do_op(1'b1, 1'b1, a, d);
        else                do_op(1'b0, 1'b0, a, d);
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
